// File: rtl/spi_slave_responder.sv
`timescale 1ns/1ps
// spi_slave_responder: SPI mode-0 responder. It oversamples the SPI pins in the clk domain and holds one TX word in a buffer.
// Optional feature: define SPI_SLAVE_RESPONDER_UNDERRUN_EN to enable the sticky tx_underrun flag (tied low otherwise).
module spi_slave_responder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic        IDLE_MISO  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun
);
    localparam int unsigned          CNT_W     = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]     LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] FILL_WORD = {DATA_WIDTH{IDLE_MISO}};

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    // Synchronisers carry no reset so that a master still holding ss_n low
    // after rst produces no spurious select edge.
    logic [2:0] r_sclk_pipe;
    logic [2:0] r_ss_pipe;
    logic [1:0] r_mosi_pipe;

    always_ff @(posedge clk) begin
        r_sclk_pipe <= {r_sclk_pipe[1:0], sclk};
        r_ss_pipe   <= {r_ss_pipe[1:0], ss_n};
        r_mosi_pipe <= {r_mosi_pipe[0], mosi};
    end

    logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise, w_mosi;
    assign w_sclk_rise = r_sclk_pipe[1] & ~r_sclk_pipe[2];
    assign w_sclk_fall = ~r_sclk_pipe[1] & r_sclk_pipe[2];
    assign w_ss_fall   = ~r_ss_pipe[1] & r_ss_pipe[2];
    assign w_ss_rise   = r_ss_pipe[1] & ~r_ss_pipe[2];
    assign w_mosi      = r_mosi_pipe[1];

    state_t                r_state;
    logic                  r_miso;
    logic                  r_oe;
    logic [DATA_WIDTH-1:0] r_buf;
    logic                  r_buf_full;
    logic [DATA_WIDTH-2:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_word_done;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;

    logic                  w_load_evt;
    logic                  w_hs;
    logic [DATA_WIDTH-1:0] w_load_word;

    // A fall with the counter at zero marks the word boundary; mode 0 never
    // sees a fall before the first rise of a frame.
    assign w_load_evt  = ((r_state == S_IDLE) && w_ss_fall) ||
                         ((r_state == S_ACTIVE) && !w_ss_rise && w_sclk_fall && (r_bit_cnt == '0));
    assign w_hs        = tx_valid && !r_buf_full;
    assign w_load_word = r_buf_full ? r_buf : FILL_WORD;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_miso      <= IDLE_MISO;
            r_oe        <= 1'b0;
            r_buf       <= '0;
            r_buf_full  <= 1'b0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_bit_cnt   <= '0;
            r_word_done <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
        end else begin
            r_rx_valid  <= r_word_done;
            r_word_done <= 1'b0;
            if (r_word_done) begin
                r_rx_data <= r_rx_shift;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_ss_fall) begin
                        r_tx_shift <= w_load_word[DATA_WIDTH-2:0];
                        r_miso     <= w_load_word[DATA_WIDTH-1];
                        r_oe       <= 1'b1;
                        r_bit_cnt  <= '0;
                        r_state    <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_ss_rise) begin
                        r_state   <= S_IDLE;
                        r_oe      <= 1'b0;
                        r_miso    <= IDLE_MISO;
                        r_bit_cnt <= '0;
                    end else if (w_sclk_rise) begin
                        r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt   <= '0;
                            r_word_done <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (w_sclk_fall) begin
                        if (r_bit_cnt == '0) begin
                            r_tx_shift <= w_load_word[DATA_WIDTH-2:0];
                            r_miso     <= w_load_word[DATA_WIDTH-1];
                        end else begin
                            r_tx_shift <= r_tx_shift << 1;
                            r_miso     <= r_tx_shift[DATA_WIDTH-2];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A handshake only happens while empty, so a simultaneous drain takes the fill word.
            if (w_hs) begin
                r_buf      <= tx_data;
                r_buf_full <= 1'b1;
            end else if (w_load_evt) begin
                r_buf_full <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_RESPONDER_UNDERRUN_EN
    logic r_underrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_underrun <= 1'b0;
        end else if (w_load_evt && !r_buf_full) begin
            r_underrun <= 1'b1;
        end else if (w_hs) begin
            r_underrun <= 1'b0;
        end
    end

    assign tx_underrun = r_underrun;
`else
    assign tx_underrun = 1'b0;
`endif

    assign miso     = r_miso;
    assign miso_oe  = r_oe;
    assign tx_ready = ~r_buf_full;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_responder.sv
`timescale 1ns/1ps
// Bench for spi_slave_responder: directed mode-0 frames plus a random burst.
// Results are scored against a word-level model of the TX buffer and RX stream.
module tb_spi_slave_responder;
    localparam logic       IDLE_MISO = 1'b0;
    localparam logic [7:0] FILL      = {8{IDLE_MISO}};
`ifdef SPI_SLAVE_RESPONDER_UNDERRUN_EN
    localparam logic UNDERRUN_ON = 1'b1;
`else
    localparam logic UNDERRUN_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclk = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic [7:0] rx_data;

    spi_slave_responder #(.DATA_WIDTH(8), .IDLE_MISO(IDLE_MISO)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Word-level model: holding buffer contents, pending RX words, sticky underrun.
    logic [7:0] buf_q[$];
    logic [7:0] exp_rx[$];
    logic       model_underrun = 1'b0;
    logic [7:0] m_mosi[$];
    logic [7:0] m_tx[$];
    logic [7:0] miso_words[$];

    logic [7:0] push_word;
    event       push_ev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_load(output logic [7:0] word);
        if (buf_q.size() != 0) begin
            word = buf_q.pop_front();
        end else begin
            word = FILL;
            model_underrun = UNDERRUN_ON;
        end
    endtask

    task automatic model_reset();
        buf_q.delete();
        exp_rx.delete();
        model_underrun = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_miso", 32'(miso), 32'(IDLE_MISO));
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_tx_underrun", 32'(tx_underrun), 32'd0);
    endtask

    task automatic pulse_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset_outputs();
    endtask

    task automatic push_tx(input logic [7:0] w);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!tx_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!tx_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL tx_ready_timeout: tx_ready=0 after 50 clk, required 1");
        end else begin
            tx_data  = w;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            buf_q.push_back(w);
            model_underrun = 1'b0;
        end
    endtask

    initial begin : feeder
        forever begin
            @(push_ev);
            push_tx(push_word);
        end
    end

    // Every rx_valid pulse must carry the next expected word and last exactly one clk.
    initial begin : compare
        logic       prev_valid;
        logic [7:0] e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                check("rx_valid_width", 32'(prev_valid), 32'd0);
                if (exp_rx.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL rx_valid_unexpected: got pulse with rx_data=%0h, required none", rx_data);
                end else begin
                    e = exp_rx.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e));
                end
            end
            prev_valid = rx_valid;
        end
    end

    // One mode-0 frame at SCLK = clk/4 with a random phase. abort_bits>0 drops
    // ss_n after that many bits; rst_bit>=0 pulses rst on that bit's rise.
    task automatic frame(input int nw, input int abort_bits, input int rst_bit, input bit feed);
        logic [7:0] exp_tx, exp_next, got;
        int         bits_done;
        bit         stopped;
        int         ph;
        stopped = 1'b0;
        if (feed) push_tx(m_tx[0]);
        ph = int'($urandom_range(9, 1));
        @(posedge clk);
        #(ph);
        ss_n = 1'b0;
        mosi = m_mosi[0][7];
        model_load(exp_tx);
        exp_next = exp_tx;
        #60;
        for (int w = 0; w < nw && !stopped; w++) begin
            got = '0;
            bits_done = 0;
            for (int b = 7; b >= 0 && !stopped; b--) begin
                sclk = 1'b1;
                if (w == 0 && rst_bit >= 0 && bits_done == rst_bit) begin
                    pulse_reset(1);
                    sclk = 1'b0;
                    stopped = 1'b1;
                end else begin
                    if (b == 0) exp_rx.push_back(m_mosi[w]);
                    if (b == 5 && feed && w + 1 < nw) begin
                        push_word = m_tx[w+1];
                        -> push_ev;
                    end
                    #19;
                    got[b] = miso;
                    check("miso_oe_active", 32'(miso_oe), 32'd1);
                    #1;
                    sclk = 1'b0;
                    if (b > 0) begin
                        mosi = m_mosi[w][b-1];
                    end else begin
                        if (w + 1 < nw) mosi = m_mosi[w+1][7];
                        model_load(exp_next);
                    end
                    bits_done++;
                    if (w == 0 && abort_bits > 0 && bits_done == abort_bits) stopped = 1'b1;
                    #20;
                end
            end
            if (!stopped) begin
                check("miso_word", 32'(got), 32'(exp_tx));
                miso_words.push_back(got);
                exp_tx = exp_next;
            end
        end
        #20;
        ss_n = 1'b1;
        #80;
        check("miso_oe_idle", 32'(miso_oe), 32'd0);
        check("miso_idle", 32'(miso), 32'(IDLE_MISO));
        check("rx_words_missing", 32'(exp_rx.size()), 32'd0);
        check("tx_ready", 32'(tx_ready), 32'(buf_q.size() == 0));
        check("tx_underrun", 32'(tx_underrun), 32'(model_underrun));
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int total;
        int nw;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset_outputs();

        // Preloaded A5 out while the master sends 3C.
        m_mosi = {8'h3C};
        m_tx   = {8'hA5};
        frame(1, 0, -1, 1'b1);
        check("t1_miso_literal", 32'(miso_words[miso_words.size()-1]), 32'hA5);
        check("t1_rx_literal", 32'(rx_data), 32'h3C);
        check("t1_tx_ready_literal", 32'(tx_ready), 32'd1);

        // Three-word burst with the buffer refilled mid-word.
        m_mosi = {8'hC1, 8'h7E, 8'h42};
        m_tx   = {8'h01, 8'h02, 8'h03};
        frame(3, 0, -1, 1'b1);
        check("t2_miso0_literal", 32'(miso_words[miso_words.size()-3]), 32'h01);
        check("t2_miso1_literal", 32'(miso_words[miso_words.size()-2]), 32'h02);
        check("t2_miso2_literal", 32'(miso_words[miso_words.size()-1]), 32'h03);
        check("t2_rx_literal", 32'(rx_data), 32'h42);

        // Empty buffer: fill on miso, underrun only when the feature is built in.
        pulse_reset(2);
        m_mosi = {8'hFF};
        frame(1, 0, -1, 1'b0);
        check("t3_miso_literal", 32'(miso_words[miso_words.size()-1]), 32'h00);
        check("t3_rx_literal", 32'(rx_data), 32'hFF);
        check("t3_underrun_literal", 32'(tx_underrun), 32'(UNDERRUN_ON));

        // Deselect after five bits, then a clean frame.
        m_mosi = {8'h66};
        m_tx   = {8'h99};
        frame(1, 5, -1, 1'b1);
        check("t4_rx_held_literal", 32'(rx_data), 32'hFF);
        m_mosi = {8'h81};
        m_tx   = {8'h3A};
        frame(1, 0, -1, 1'b1);
        check("t4_rx_literal", 32'(rx_data), 32'h81);
        check("t4_miso_literal", 32'(miso_words[miso_words.size()-1]), 32'h3A);

        // Reset in the middle of bit 3, then a following frame.
        m_mosi = {8'hE7};
        m_tx   = {8'h55};
        frame(1, 0, 3, 1'b1);
        m_mosi = {8'h5A};
        m_tx   = {8'hC3};
        frame(1, 0, -1, 1'b1);
        check("t5_rx_literal", 32'(rx_data), 32'h5A);
        check("t5_miso_literal", 32'(miso_words[miso_words.size()-1]), 32'hC3);

        // 1000 random words in frames of 1..4 words.
        total = 0;
        while (total < 1000) begin
            nw = int'($urandom_range(4, 1));
            if (total + nw > 1000) nw = 1000 - total;
            m_mosi.delete();
            m_tx.delete();
            for (int i = 0; i < nw; i++) begin
                m_mosi.push_back(8'($urandom));
                m_tx.push_back(8'($urandom));
            end
            frame(nw, 0, -1, 1'b1);
            total += nw;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
